// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC generator feeding a DEPTH-entry prefetch FIFO toward decode
module fetch_queue #(
   parameter int unsigned           XLEN     = 32,
   parameter int unsigned           DEPTH    = 4,
   parameter logic [XLEN-1:0]       RESET_PC = '0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   output logic [XLEN-1:0]           imem_addr,
   input  logic [31:0]               imem_data,
   input  logic                      imem_valid,
   input  logic                      redirect_valid,
   input  logic [XLEN-1:0]           redirect_pc,
   output logic                      deq_valid,
   input  logic                      deq_ready,
   output logic [31:0]               deq_instr,
   output logic [XLEN-1:0]           deq_pcplus4,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count_q;
   logic [31:0]     instr_mem [DEPTH];
   logic [XLEN-1:0] pcp4_mem  [DEPTH];
   logic            enq;
   logic            deq;

   assign pc_plus4    = pc + XLEN'(4);
   assign imem_addr   = pc;
   assign count       = count_q;
   assign deq_valid   = (count_q != '0);
   assign deq         = deq_valid & deq_ready;
   // A full queue may still accept when its head leaves in the same cycle
   assign enq         = imem_valid & ~redirect_valid & ((count_q < FULL_COUNT) | deq);
   assign deq_instr   = instr_mem[rd_ptr];
   assign deq_pcplus4 = pcp4_mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc      <= RESET_PC;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem[i] <= '0;
            pcp4_mem[i]  <= '0;
         end
      end else if (redirect_valid) begin
         // Flush: queued entries and any head being consumed are dropped
         pc      <= redirect_pc;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (enq) begin
            instr_mem[wr_ptr] <= imem_data;
            pcp4_mem[wr_ptr]  <= pc_plus4;
            wr_ptr            <= wr_ptr + PW'(1);
            pc                <= pc_plus4;
         end
         if (deq) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (enq && !deq) begin
            count_q <= count_q + CW'(1);
         end else if (deq && !enq) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with directed and random fetch traffic
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        imem_valid;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        deq_valid;
   logic        deq_ready;
   logic [31:0] deq_instr;
   logic [31:0] deq_pcplus4;
   logic [2:0]  count;

   int n_pass  = 0;
   int n_total = 0;

   logic [63:0] exp_q [$];
   logic [31:0] m_pc;

   always #5 clk = ~clk;

   assign imem_data = 32'hA000_0000 | imem_addr;

   fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .imem_valid     (imem_valid),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .deq_valid      (deq_valid),
      .deq_ready      (deq_ready),
      .deq_instr      (deq_instr),
      .deq_pcplus4    (deq_pcplus4),
      .count          (count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // One clock of stimulus; the model advances after the edge from queue arithmetic
   task automatic cycle(input logic iv, input logic dr, input logic rv, input logic [31:0] rpc);
      bit deq_m, enq_m;
      @(negedge clk);
      imem_valid     = iv;
      deq_ready      = dr;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      check("imem_addr", imem_addr, m_pc);
      deq_m = (exp_q.size() != 0) && dr;
      enq_m = iv && !rv && ((exp_q.size() < 4) || deq_m);
      @(posedge clk);
      #1;
      if (rv) begin
         exp_q.delete();
         m_pc = rpc;
      end else if (enq_m) begin
         exp_q.push_back({32'hA000_0000 | m_pc, m_pc + 32'd4});
         m_pc = m_pc + 32'd4;
      end
   endtask

   // Monitor: compares occupancy and pops the expected entry on every accepted dequeue
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         #2;
         check("count", {29'd0, count}, exp_q.size());
         check("deq_valid", {31'd0, deq_valid}, {31'd0, exp_q.size() != 0});
         if (reset_n && deq_valid && deq_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL deq_unexpected: got pcplus4 0x%08h expected no entry", deq_pcplus4);
            end else begin
               e = exp_q.pop_front();
               check("deq_instr", deq_instr, e[63:32]);
               check("deq_pcplus4", deq_pcplus4, e[31:0]);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: got no finish expected finish before 400000");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n        = 1'b0;
      imem_valid     = 1'b0;
      deq_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      m_pc           = 32'h0;
      #1;
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_count", {29'd0, count}, 32'd0);
      check("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
      check("rst_deq_instr", deq_instr, 32'h0);
      check("rst_deq_pcplus4", deq_pcplus4, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Fill while decode is stalled
      repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("fill_count", {29'd0, count}, 32'd4);
      check("fill_imem_addr", imem_addr, 32'h10);
      check("fill_head_pcplus4", deq_pcplus4, 32'h4);
      check("fill_head_instr", deq_instr, 32'hA000_0000);

      // Full plus dequeue keeps count at DEPTH
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("fulldeq_count", {29'd0, count}, 32'd4);
      check("fulldeq_imem_addr", imem_addr, 32'h14);
      check("fulldeq_head_pcplus4", deq_pcplus4, 32'h8);

      // Bring count to 3, then redirect while dequeuing
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b1, 32'h100);
      check("redir_count", {29'd0, count}, 32'd0);
      check("redir_deq_valid", {31'd0, deq_valid}, 32'd0);
      check("redir_imem_addr", imem_addr, 32'h100);
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("redir_head_instr", deq_instr, 32'hA000_0100);
      check("redir_head_pcplus4", deq_pcplus4, 32'h104);

      // imem wait states: nothing moves, then the held address enqueues once
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
      check("wait_imem_addr", imem_addr, 32'h104);
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("wait_resume_count", {29'd0, count}, 32'd2);

      // Streaming from a fresh redirect: count settles at 1
      cycle(1'b0, 1'b1, 1'b1, 32'h200);
      repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("stream_count", {29'd0, count}, 32'd1);

      // PC wrap across 2^32
      cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
      repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("wrap_imem_addr", imem_addr, 32'h8);
      repeat (6) cycle(1'b0, 1'b1, 1'b0, 32'h0);

      // Asynchronous reset between edges with two entries queued
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      imem_valid = 1'b0;
      deq_ready  = 1'b0;
      #3;
      reset_n = 1'b0;
      #1;
      check("async_count", {29'd0, count}, 32'd0);
      check("async_deq_valid", {31'd0, deq_valid}, 32'd0);
      check("async_imem_addr", imem_addr, 32'h0);
      exp_q.delete();
      m_pc = 32'h0;
      @(negedge clk);
      reset_n = 1'b1;
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("post_reset_head_pcplus4", deq_pcplus4, 32'h4);

      // Randomized traffic with occasional redirects
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
         cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 19) == 0), rpc);
      end

      @(negedge clk);
      #3;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end that replaces the single PC register plus IF/ID register pair with a PC generator feeding a DEPTH-entry prefetch FIFO. It sits between instruction memory and the decode stage. It keeps fetching while decode is stalled, up to DEPTH entries. It delivers {instruction, PC+4} to decode over a valid/ready handshake and flushes on a branch/jump redirect from the execute stage.

## Interface
Parameters:
- XLEN, 32, address / PC width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_addr  out  XLEN  fetch address; equal to the current PC register.
- imem_data  in  32  instruction at imem_addr, combinational (same cycle).
- imem_valid  in  1  imem_data is valid this cycle.
- redirect_valid  in  1  branch taken / jump; flush and reload PC.
- redirect_pc  in  XLEN  new fetch address.
- deq_valid  out  1  head entry is valid.
- deq_ready  in  1  decode accepts the head entry (decode not stalled).
- deq_instr  out  32  head instruction.
- deq_pcplus4  out  XLEN  PC+4 of the head instruction.
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.

## Operation
- State: pc, DEPTH-entry storage of {instr, pcplus4}, rd_ptr, wr_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), and count.
- deq = deq_valid & deq_ready. deq_valid = (count != 0).
- enq = imem_valid & ~redirect_valid & ((count < DEPTH) | deq).
- On enq: write {imem_data, pc+4} at wr_ptr, advance wr_ptr, set pc <= pc+4.
- No enq and no redirect: pc holds.
- On deq without redirect: advance rd_ptr.
- count update: +1 on enq only, -1 on deq only, unchanged when both or neither occur.
- Redirect has the highest priority. It sets count <= 0, rd_ptr <= 0, wr_ptr <= 0 and pc <= redirect_pc. That cycle there is no enqueue, and any deq is ignored (the entry is discarded). Storage contents are not cleared.
- Full with simultaneous deq: enqueue is permitted, so count stays at DEPTH.
- Empty with simultaneous enq: there is no bypass. deq_valid stays 0 that cycle and the entry becomes visible after the edge.
- deq_instr and deq_pcplus4 come from storage at rd_ptr. They have no combinational path from imem_data.
- PC arithmetic is modulo 2^XLEN. PC 0xFFFF_FFFC wraps to 0.

## Timing
- While reset_n = 0, outputs are forced immediately, with no clock edge required:
  - pc = RESET_PC, so imem_addr = RESET_PC
  - count = 0, deq_valid = 0
  - all storage = 0, so deq_instr = 0 and deq_pcplus4 = 0
  - pointers = 0
- Fetch-to-decode latency is 1 cycle. An instruction presented with enq at edge N appears at the head after edge N (if the FIFO was empty) and can be consumed at edge N+1.
- Throughput is 1 instruction per cycle when imem_valid=1 and deq_ready=1 continuously. Steady-state count = 1.
- Redirect penalty: at the edge after redirect_valid, count = 0 and imem_addr = redirect_pc. The first redirected instruction is at the head one edge later.
- Reset asserted mid-operation discards all entries asynchronously. After deassertion, the first edge fetches RESET_PC.
- deq_valid must not depend combinationally on deq_ready.

## Test plan
Common setup: DEPTH=4, RESET_PC=0, imem_data = 32'hA000_0000 | imem_addr.
- Fill while stalled: release reset with deq_ready=0 and imem_valid=1 for 5 edges -> count=4 and imem_addr holds 0x10. Draining then yields deq_pcplus4 = 0x4, 0x8, 0xC, 0x10 with deq_instr = 0xA000_0000 .. 0xA000_000C.
- Streaming: deq_ready=1 and imem_valid=1 from reset -> deq_valid rises after edge 1. deq_pcplus4 increments by 4 every cycle and count stays 1.
- Full plus dequeue: with count=4, pulse deq_ready=1 for one cycle -> count stays 4, imem_addr advances 0x10 -> 0x14, and the head moves to pcplus4 0x8.
- Redirect: with count=3 and deq_ready=1, assert redirect_valid with redirect_pc=0x100 -> next cycle count=0, deq_valid=0, imem_addr=0x100. After the following edge, the head holds instr 0xA000_0100 and pcplus4 0x104.
- imem wait: hold imem_valid=0 for 3 cycles with deq_ready=0 -> count and imem_addr are unchanged. Resuming enqueues the held address exactly once.
- Async reset: drop reset_n between clock edges while count=2 -> count=0, deq_valid=0 and imem_addr=0 before the next edge.
